// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// produces {remainder, quotient} for the HI/LO register file.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    // The remainder stays below the divisor, so the 33-bit trial
    // difference always fits back into WIDTH bits when it is kept.
    trial = {rem_q, dvd_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = (trial >= {1'b0, dvs_q});
    q_fix = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
    r_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            cnt_d   = '0;
            rem_d   = '0;
            if (signed_div_i) begin
              dvd_d  = opdata1_i[WIDTH-1] ? (~opdata1_i + 1'b1) : opdata1_i;
              dvs_d  = opdata2_i[WIDTH-1] ? (~opdata2_i + 1'b1) : opdata2_i;
              qneg_d = opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
              rneg_d = opdata1_i[WIDTH-1];
            end else begin
              dvd_d  = opdata1_i;
              dvs_d  = opdata2_i;
              qneg_d = 1'b0;
              rneg_d = 1'b0;
            end
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = END;
          result_d = '0;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(WIDTH)) begin
            state_d  = END;
            result_d = {r_fix, q_fix};
          end else begin
            rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], ge};
          end
        end
      end
      END: begin
        if (!start_i) begin
          state_d  = IDLE;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; no path from the inputs.
  always_comb begin
    ready_o  = (state_q == END);
    busy_o   = (state_q == BYZERO) || (state_q == ON);
    result_o = ready_o ? result_q : '0;
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus random ops through a
// scoreboard queue, and hand-written annul/reset sequences.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] sb_q[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge with the DUT idle; E0 is the following posedge.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int lat, busy_n;
    logic [63:0] want;
    sb_q.push_back(exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat    = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy_o) busy_n++;
      if (lat == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end while (!ready_o && lat < 100);
    want = sb_q.pop_front();
    if (!ready_o) begin
      chk("ready_timeout", 64'(ready_o), 64'd1);
    end else begin
      chk("result", result_o, want);
      chk("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
      chk("busy_cycles", 64'(busy_n), (b == 32'd0) ? 64'd1 : 64'd33);
      @(negedge clk);
      chk("end_hold_ready", 64'(ready_o), 64'd1);
      chk("end_hold_result", result_o, want);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("exit_ready", 64'(ready_o), 64'd0);
    chk("exit_result", result_o, 64'd0);
  endtask

  initial begin
    int hits;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
    vecs[5] = '{1'b0, 32'd12345,      32'd0,          64'h0};
    vecs[6] = '{1'b1, 32'hFFFFFF00,   32'd0,          64'h0};
    vecs[7] = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000};
    vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};

    #3;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 6; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(1));
      a = $urandom;
      b = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(31));
      run_op(s, a, b, model(s, a, b));
    end

    // Simultaneous start and annul in IDLE: annul wins.
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    @(negedge clk);
    chk("start_annul_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    chk("start_annul_busy2", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);

    // Annul at E0+10 of DIVU 1000/3.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_annul_busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy", 64'(busy_o), 64'd0);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o || busy_o) hits++;
    end
    chk("annul_no_ready", 64'(hits), 64'd0);
    run_op(1'b0, 32'd9, 32'd4, 64'h00000001_00000002);

    // Asynchronous reset between edges while ON.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 64'(busy_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy_o), 64'd0);
    chk("async_reset_ready", 64'(ready_o), 64'd0);
    chk("async_reset_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
